// File: rtl/alu_execute.sv
// alu_execute: MIPS execute stage. It evaluates the ALU operation on the two
// operands and registers the result, the zero flag and the destination index
// into a two-entry skid buffer that feeds the EX/MEM boundary.
//
// Optional feature macro: ALU_OVERFLOW_EN (adds the registered overflow port).
//
// Ports:
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   flush             drop buffered entries and the incoming beat
//   in_valid/in_ready upstream handshake (in_ready is registered)
//   operation         4-bit ALU control code
//   operand_a/_b      DATA_WIDTH operands
//   dest_reg          write-back register index
//   out_valid/ready   downstream handshake
//   result, zero      registered ALU result and result==0 flag
//   out_dest_reg      registered destination index
//   overflow          signed ADD/SUB overflow (ALU_OVERFLOW_EN only)
module alu_execute #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                operation,
  input  logic [DATA_WIDTH-1:0]     operand_a,
  input  logic [DATA_WIDTH-1:0]     operand_b,
  input  logic [REG_ADDR_WIDTH-1:0] dest_reg,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     result,
  output logic                      zero,
  output logic [REG_ADDR_WIDTH-1:0] out_dest_reg
`ifdef ALU_OVERFLOW_EN
  ,
  output logic                      overflow
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_TWO
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     res;
    logic                      zero;
    logic [REG_ADDR_WIDTH-1:0] dest;
`ifdef ALU_OVERFLOW_EN
    logic                      ovf;
`endif
  } entry_t;

  state_t r_state, w_state_nxt;
  logic   r_in_ready;
  entry_t r_main, r_skid;
  entry_t w_beat;

  logic [DATA_WIDTH-1:0] w_sum, w_diff, w_res;
  logic                  w_lt;
  logic                  w_accept, w_drain;
  logic                  w_load_main, w_load_skid, w_main_from_skid;

  assign w_sum  = operand_a + operand_b;
  assign w_diff = operand_a - operand_b;
  // Signed compare rather than the sign of a-b, so SLT stays correct when
  // the subtraction overflows.
  assign w_lt   = $signed(operand_a) < $signed(operand_b);

  always_comb begin
    w_res = '0;
    unique case (operation)
      4'b0000: w_res = operand_a & operand_b;
      4'b0001: w_res = operand_a | operand_b;
      4'b0010: w_res = w_sum;
      4'b0110: w_res = w_diff;
      4'b0111: w_res = {{(DATA_WIDTH-1){1'b0}}, w_lt};
      4'b1100: w_res = ~(operand_a | operand_b);
      default: w_res = '0;
    endcase
  end

  always_comb begin
    w_beat      = '0;
    w_beat.res  = w_res;
    w_beat.zero = (w_res == '0);
    w_beat.dest = dest_reg;
`ifdef ALU_OVERFLOW_EN
    unique case (operation)
      4'b0010: w_beat.ovf = (operand_a[DATA_WIDTH-1] == operand_b[DATA_WIDTH-1]) &&
                            (w_sum[DATA_WIDTH-1] != operand_a[DATA_WIDTH-1]);
      4'b0110: w_beat.ovf = (operand_a[DATA_WIDTH-1] != operand_b[DATA_WIDTH-1]) &&
                            (w_diff[DATA_WIDTH-1] != operand_a[DATA_WIDTH-1]);
      default: w_beat.ovf = 1'b0;
    endcase
`endif
  end

  assign w_accept = in_valid & r_in_ready;
  assign w_drain  = (r_state != S_EMPTY) & out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    unique case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = S_ONE;
          w_load_main = 1'b1;
        end
      end
      S_ONE: begin
        if (w_accept && w_drain) begin
          w_load_main = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = S_TWO;
          w_load_skid = 1'b1;
        end else if (w_drain) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_drain) begin
          w_state_nxt      = S_ONE;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    // A drain in the flush cycle still completes; only buffered and
    // incoming beats are dropped.
    if (flush) begin
      w_state_nxt      = S_EMPTY;
      w_load_main      = 1'b0;
      w_load_skid      = 1'b0;
      w_main_from_skid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
      r_main     <= '0;
      r_skid     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      // Derived from the next state so ready never depends on out_ready
      // within the same cycle.
      r_in_ready <= (w_state_nxt != S_TWO);
      if (w_load_main) begin
        r_main <= w_beat;
      end else if (w_main_from_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_beat;
      end
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = (r_state != S_EMPTY);
  assign result       = r_main.res;
  assign zero         = r_main.zero;
  assign out_dest_reg = r_main.dest;
`ifdef ALU_OVERFLOW_EN
  assign overflow     = r_main.ovf;
`endif

endmodule

// File: tb/tb_alu_execute.sv
// Testbench for alu_execute: random and directed beats, a two-deep FIFO
// reference with a queue, and a monitor comparing the presented output.
module tb_alu_execute;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready, zero;
  logic [3:0]    operation;
  logic [DW-1:0] operand_a, operand_b, result;
  logic [AW-1:0] dest_reg, out_dest_reg;
`ifdef ALU_OVERFLOW_EN
  logic          overflow;
`endif

  alu_execute #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .operand_a(operand_a), .operand_b(operand_b),
    .dest_reg(dest_reg),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .out_dest_reg(out_dest_reg)
`ifdef ALU_OVERFLOW_EN
    , .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] res;
    logic          zero;
    logic [AW-1:0] dest;
    logic          ovf;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  bit   snap_ready;
  bit   last_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference computed with wide signed arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [DW-1:0] a,
                                 input logic [DW-1:0] b, input logic [AW-1:0] d);
    exp_t   e;
    longint sa, sb, wide;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dest = d;
    e.ovf  = 1'b0;
    e.res  = '0;
    case (op)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0010: begin
        wide  = sa + sb;
        e.res = wide[DW-1:0];
        e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'b0110: begin
        wide  = sa - sb;
        e.res = wide[DW-1:0];
        e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'b0111: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'b1100: e.res = ~(a | b);
      default: e.res = '0;
    endcase
    e.zero = (e.res == 0);
    return e;
  endfunction

  // Monitor: checks occupancy-derived handshakes and the head-of-queue beat
  // every cycle it is presented, so stalled outputs must stay stable.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t h;
      snap_ready = (q.size() < 2);
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(snap_ready));
      if (out_valid && q.size() > 0) begin
        h = q[0];
        chk("result", 64'(result), 64'(h.res));
        chk("zero", 64'(zero), 64'(h.zero));
        chk("out_dest_reg", 64'(out_dest_reg), 64'(h.dest));
`ifdef ALU_OVERFLOW_EN
        chk("overflow", 64'(overflow), 64'(h.ovf));
`endif
        if (out_ready) void'(q.pop_front());
      end
    end else begin
      snap_ready = 1'b0;
    end
  end

  // One clock: decide acceptance just after the monitor, end at posedge+1.
  task automatic step();
    @(negedge clk);
    #1;
    last_acc = 1'b0;
    if (!rst_n || flush) begin
      q.delete();
    end else if (in_valid && snap_ready) begin
      q.push_back(model(operation, operand_a, operand_b, dest_reg));
      last_acc = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [DW-1:0] a,
                      input logic [DW-1:0] b, input logic [AW-1:0] d);
    bit done = 1'b0;
    in_valid  = 1'b1;
    operation = op;
    operand_a = a;
    operand_b = b;
    dest_reg  = d;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      done = last_acc;
    end
    if (!done) chk("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [3:0] rand_op();
    logic [3:0] ops [7];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1111};
    if ($urandom_range(0, 9) == 0) return 4'($urandom);
    return ops[$urandom_range(0, 6)];
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    operation = '0; operand_a = '0; operand_b = '0; dest_reg = '0;
    repeat (2) step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    chk("rst_dest", 64'(out_dest_reg), 64'd0);
`ifdef ALU_OVERFLOW_EN
    chk("rst_overflow", 64'(overflow), 64'd0);
`endif
    rst_n = 1'b1;
    step();

    // Directed operation corners with the sink always ready.
    out_ready = 1'b1;
    send(4'b0010, 32'h0000_0005, 32'h0000_0003, 5'd1);
    chk("add_latency_valid", 64'(out_valid), 64'd1);
    chk("add_latency_result", 64'(result), 64'h8);
    send(4'b0110, 32'h1234_5678, 32'h1234_5678, 5'd2);
    send(4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 5'd3);
    send(4'b1100, 32'h0, 32'h0, 5'd4);
    send(4'b1111, 32'h1234_0000, 32'h5, 5'd5);
    send(4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd6);
    send(4'b0110, 32'h8000_0000, 32'h1, 5'd7);
    send(4'b0000, 32'hFFFF_FFFF, 32'h8000_0000, 5'd8);
    repeat (3) step();

    // Three back-to-back beats into a stalled sink.
    out_ready = 1'b0;
    send(4'b0001, 32'h1, 32'h2, 5'd10);
    send(4'b0001, 32'h4, 32'h8, 5'd11);
    in_valid = 1'b1; operation = 4'b0010; operand_a = 32'd100; operand_b = 32'd23; dest_reg = 5'd12;
    repeat (2) step();
    chk("stall_in_ready_low", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    send(4'b0010, 32'd100, 32'd23, 5'd12);
    repeat (4) step();

    // Flush while full, with a beat offered in the same cycle.
    out_ready = 1'b0;
    send(4'b0010, 32'd1, 32'd1, 5'd20);
    send(4'b0010, 32'd2, 32'd2, 5'd21);
    in_valid = 1'b1; operation = 4'b0001; operand_a = 32'hF0; operand_b = 32'h0F; dest_reg = 5'd22;
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) step();

    // Reset while full.
    out_ready = 1'b0;
    send(4'b0010, 32'd9, 32'd9, 5'd30);
    send(4'b0010, 32'd8, 32'd8, 5'd31);
    rst_n = 1'b0;
    step();
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    step();

    // Random traffic with random back-pressure and occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      operation = rand_op();
      operand_a = rand_word();
      operand_b = rand_word();
      dest_reg  = 5'($urandom);
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    chk("final_drained", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_execute.md
# alu_execute

Execute stage of the MIPS datapath, sitting directly downstream of the ALU control decoder: it consumes the 4-bit ALU operation code together with the two 32-bit operands and destination register, computes the ALU result and zero flag, and registers them into the EX/MEM boundary. A two-entry skid buffer with valid/ready handshakes on both sides lets the memory stage stall without combinational ready paths back into decode. A synchronous flush discards in-flight work on branch/jump redirect.

## Interface
- DATA_WIDTH, 32, operand and result width
- REG_ADDR_WIDTH, 5, destination register index width
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- flush  input  1  discard all buffered entries and the incoming beat
- in_valid  input  1  upstream beat valid
- in_ready  output  1  stage can accept a beat; registered
- operation  input  4  ALU operation code from ALU control
- operand_a  input  DATA_WIDTH  rs value
- operand_b  input  DATA_WIDTH  rt value or sign-extended immediate
- dest_reg  input  REG_ADDR_WIDTH  write-back register index
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts the beat
- result  output  DATA_WIDTH  ALU result
- zero  output  1  result == 0
- out_dest_reg  output  REG_ADDR_WIDTH  registered dest_reg
- overflow  output  1  signed overflow on ADD/SUB (present only with ALU_OVERFLOW_EN)

## Operation
- Operation codes: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0111 SLT (1 if $signed(a) < $signed(b), else 0, correct even when a−b overflows); 1100 NOR. Any other code: result 0, zero 1.
- Arithmetic is modulo 2^DATA_WIDTH; ADD/SUB wrap silently.
- zero is derived from the computed result and registered alongside it.
- Storage: main register (drives outputs) and skid register. States: EMPTY (none valid), ONE (main valid), TWO (main + skid valid).
- in_ready = 1 in EMPTY and ONE, 0 in TWO. Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- EMPTY: accept → ONE (beat to main).
- ONE: accept & drain → ONE (new beat to main); accept & !drain → TWO (beat to skid); !accept & drain → EMPTY; else hold.
- TWO: drain → ONE (skid moves to main); else hold. No accept possible.
- out_valid = 1 in ONE and TWO. Outputs stay stable while out_valid & !out_ready.
- Order is strict FIFO; no beat duplicated or dropped except by flush.
- flush: next state EMPTY regardless of accept/drain; incoming beat in the flush cycle is discarded; a beat draining in the flush cycle counts as delivered.

## Timing
- Reset (rst_n low at a clock edge): state EMPTY; out_valid 0, in_ready 1, result 0, zero 0, out_dest_reg 0, overflow 0. Reset mid-operation discards all entries; reset dominates flush.
- Latency: beat accepted at edge N is on outputs from edge N (visible in cycle N+1) when stage was EMPTY or draining.
- Throughput: one beat per cycle with out_ready held high.
- in_ready falls the cycle after the second entry is captured and rises the cycle after a drain from TWO.
- No combinational path from out_ready to in_ready.

## Configuration
- ALU_OVERFLOW_EN defined: overflow port exists; set for ADD when operands share sign and result sign differs, for SUB when operand signs differ and result sign differs from operand_a; 0 for all other codes; registered and buffered with result.
- Undefined: overflow port and logic absent; all wraps silent.

## Test plan
- ADD a=0x0000_0005, b=0x0000_0003, out_ready=1 → one cycle later result=0x0000_0008, zero=0, out_valid=1.
- SUB a=b=0x1234_5678 → result 0, zero=1; SLT a=0x8000_0000, b=0x7FFF_FFFF → result 1; NOR a=b=0 → 0xFFFF_FFFF; code 1111 → result 0, zero=1.
- out_ready=0, present three beats back-to-back → first two accepted, in_ready 0 on third; release out_ready → beats emerge in order, third accepted when in_ready rises.
- State TWO, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, no beat ever emitted.
- With ALU_OVERFLOW_EN: ADD 0x7FFF_FFFF + 1 → result 0x8000_0000, overflow=1; SUB 0x8000_0000 − 1 → overflow=1; AND → overflow=0.
- Drive rst_n low while in TWO → next edge out_valid=0, result=0, in_ready=1.
